bc1_decode_sched: RTL and testbench

//  Shares one combinational BC1 block decoder among NUM_REQ texture-sampler requesters.

---
 rtl/bc1_decode_sched.sv | 160 ++++++++++++++++
 tb/tb_bc1_decode_sched.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bc1_decode_sched.sv
// bc1_decode_sched
//   Shares one combinational BC1 block decoder among NUM_REQ texture-sampler
//   requesters. A round-robin arbiter feeds 64-bit BC1 blocks into a two-stage
//   pipeline: stage A (input register, which drives the shared decoder) and
//   stage B (the registered rsp_* outputs that capture the decoder result).
//
// Ports
//   clk, rst_n     clock; synchronous active-low reset
//   req_valid      per-requester request valid
//   req_ready      per-requester accept (one-hot or zero)
//   req_block      BC1 blocks, requester k at [64*k +: 64]
//   req_tag        opaque tags, requester k at [TAG_W*k +: TAG_W]
//   dec_block      block presented to the shared decoder (stage A register)
//   dec_pixels     decoder result, combinational from dec_block
//   rsp_valid      decoded texels valid
//   rsp_ready      consumer accepts response
//   rsp_pixels     16 x RGBA8888, pixel0 at [31:0]
//   rsp_id         originating requester
//   rsp_tag        originating tag
//   busy           either pipeline stage holds data
//   perf_accepts   accepted requests (saturating)
//   perf_stalls    cycles with a pending request but no accept (saturating)
//
// Configuration
//   BC1_SCHED_PERF_EN  when defined, builds the saturating performance counters;
//                      otherwise perf_accepts and perf_stalls are tied to zero.

module bc1_decode_sched #(
  parameter  int NUM_REQ = 4,
  parameter  int TAG_W   = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*64-1:0]    req_block,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [63:0]              dec_block,
  input  logic [511:0]             dec_pixels,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [511:0]             rsp_pixels,
  output logic [ID_W-1:0]          rsp_id,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     busy,
  output logic [31:0]              perf_accepts,
  output logic [31:0]              perf_stalls
);

  logic              a_valid;
  logic [63:0]       a_block;
  logic [TAG_W-1:0]  a_tag;
  logic [ID_W-1:0]   a_id;
  logic [ID_W-1:0]   rr_ptr;

  logic              a_adv;
  logic              a_free;
  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic              accept;
  logic [63:0]       sel_block;
  logic [TAG_W-1:0]  sel_tag;

  // Adds an offset to a requester index and wraps modulo NUM_REQ. Both operands
  // are below NUM_REQ, so a single conditional subtract is enough even when
  // NUM_REQ is not a power of two.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  // Stage A drains into stage B whenever B is empty or being consumed, and can
  // take a new block in that same cycle.
  assign a_adv  = a_valid & (~rsp_valid | rsp_ready);
  assign a_free = ~a_valid | a_adv;

  // Round-robin search starting at rr_ptr; the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[wrap_add(rr_ptr, i)]) begin
        grant_found = 1'b1;
        grant_id    = wrap_add(rr_ptr, i);
      end
    end
  end

  // Ready is suppressed during reset so no requester sees a handshake that the
  // pipeline is about to discard.
  assign accept    = grant_found & a_free & rst_n;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;
  assign sel_block = req_block[64*grant_id +: 64];
  assign sel_tag   = req_tag[TAG_W*grant_id +: TAG_W];

  assign dec_block = a_block;
  assign busy      = a_valid | rsp_valid;

  // Pipeline registers. Stage A loads on accept and empties when it advances
  // without a replacement; stage B loads on advance and clears once consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_valid    <= 1'b0;
      a_block    <= '0;
      a_tag      <= '0;
      a_id       <= '0;
      rr_ptr     <= '0;
      rsp_valid  <= 1'b0;
      rsp_pixels <= '0;
      rsp_id     <= '0;
      rsp_tag    <= '0;
    end else begin
      if (accept) begin
        a_valid <= 1'b1;
        a_block <= sel_block;
        a_tag   <= sel_tag;
        a_id    <= grant_id;
        rr_ptr  <= wrap_add(grant_id, 1);
      end else if (a_adv) begin
        a_valid <= 1'b0;
      end

      if (a_adv) begin
        rsp_valid  <= 1'b1;
        rsp_pixels <= dec_pixels;
        rsp_id     <= a_id;
        rsp_tag    <= a_tag;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef BC1_SCHED_PERF_EN
  logic [31:0] accepts_q;
  logic [31:0] stalls_q;

  // Saturating event counters; a stall is any cycle with a pending request
  // that is not accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      accepts_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (accept && (accepts_q != 32'hFFFF_FFFF)) accepts_q <= accepts_q + 32'd1;
      if ((|req_valid) && !accept && (stalls_q != 32'hFFFF_FFFF)) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign perf_accepts = accepts_q;
  assign perf_stalls  = stalls_q;
`else
  assign perf_accepts = 32'd0;
  assign perf_stalls  = 32'd0;
`endif

endmodule

// File: tb/tb_bc1_decode_sched.sv
// Testbench for bc1_decode_sched with NUM_REQ=4, TAG_W=8. The shared decoder is
// modelled here as a BC1 reference function driving dec_pixels from dec_block.

module tb_bc1_decode_sched;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 8;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*64-1:0]    req_block;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [63:0]              dec_block;
  logic [511:0]             dec_pixels;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [511:0]             rsp_pixels;
  logic [ID_W-1:0]          rsp_id;
  logic [TAG_W-1:0]         rsp_tag;
  logic                     busy;
  logic [31:0]              perf_accepts;
  logic [31:0]              perf_stalls;

  logic [63:0] blocks [NUM_REQ];
  logic [7:0]  tags   [NUM_REQ];

  int n_vec  = 0;
  int n_miss = 0;

  bc1_decode_sched #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_block(req_block), .req_tag(req_tag),
    .dec_block(dec_block), .dec_pixels(dec_pixels),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_pixels(rsp_pixels), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .busy(busy), .perf_accepts(perf_accepts), .perf_stalls(perf_stalls)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // BC1 reference decode: color0 at [63:48], color1 at [47:32], 2-bit indices
  // with pixel p at [2p+1:2p]; output RGBA8888 with R in the low byte.
  function automatic logic [511:0] bc1_model(input logic [63:0] blk);
    logic [15:0]  c0, c1;
    int           r[4], g[4], b[4], a[4];
    int           ix;
    logic [511:0] px;
    c0 = blk[63:48];
    c1 = blk[47:32];
    r[0] = int'({c0[15:11], c0[15:13]});
    g[0] = int'({c0[10:5],  c0[10:9]});
    b[0] = int'({c0[4:0],   c0[4:2]});
    r[1] = int'({c1[15:11], c1[15:13]});
    g[1] = int'({c1[10:5],  c1[10:9]});
    b[1] = int'({c1[4:0],   c1[4:2]});
    for (int k = 0; k < 4; k++) a[k] = 255;
    if (c0 > c1) begin
      r[2] = (2*r[0] + r[1]) / 3;  r[3] = (r[0] + 2*r[1]) / 3;
      g[2] = (2*g[0] + g[1]) / 3;  g[3] = (g[0] + 2*g[1]) / 3;
      b[2] = (2*b[0] + b[1]) / 3;  b[3] = (b[0] + 2*b[1]) / 3;
    end else begin
      r[2] = (r[0] + r[1]) / 2;  r[3] = 0;
      g[2] = (g[0] + g[1]) / 2;  g[3] = 0;
      b[2] = (b[0] + b[1]) / 2;  b[3] = 0;
      a[3] = 0;
    end
    px = '0;
    for (int p = 0; p < 16; p++) begin
      ix = int'(blk[2*p +: 2]);
      px[32*p +: 32] = {8'(a[ix]), 8'(b[ix]), 8'(g[ix]), 8'(r[ix])};
    end
    return px;
  endfunction

  assign dec_pixels = bc1_model(dec_block);

  // Compares one value and reports a miscompare on a single line.
  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] rv, input logic rr);
    req_valid = rv;
    rsp_ready = rr;
  endtask

  // Advances one clock and lands 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] rv;
    logic       rr;
    logic [3:0] exp_ready;
    logic       exp_rsp_valid;
    logic [1:0] exp_id;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [9];

  // Safety net so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] hs;
    logic [511:0]       snap_pix;
    logic [ID_W-1:0]    snap_id;
    logic [TAG_W-1:0]   snap_tag;
    int                 accepts;
    int                 resp_cnt;
    int                 last_id;
    int                 exp_order [3];
    logic [ID_W-1:0]    got [$];

    blocks[0] = 64'h001F_F800_E4E4_E4E4;  tags[0] = 8'h3C;
    blocks[1] = 64'h07E0_F81F_1B1B_1B1B;  tags[1] = 8'h81;
    blocks[2] = 64'hF800_001F_0000_0000;  tags[2] = 8'h5A;
    blocks[3] = 64'hFFFF_0000_AAAA_5555;  tags[3] = 8'hC3;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_block[64*k +: 64]       = blocks[k];
      req_tag[TAG_W*k +: TAG_W]   = tags[k];
    end

    // rv, rsp_ready, req_ready before edge, then rsp_valid / rsp_id / busy after it
    vecs[0] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1};
    vecs[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b1};
    vecs[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b1};
    vecs[3] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 1'b1};
    vecs[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 1'b1};
    vecs[5] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd0, 1'b1};
    vecs[6] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd2, 1'b1};
    vecs[7] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
    vecs[8] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};

    // Reset held three clocks with every requester asking.
    rst_n = 1'b0;
    applyStimulus(4'b1111, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("rst_ready_c%0d", c), req_ready, 4'b0000);
    end
    checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_dec_block", dec_block, 64'd0);
    checkOutput("rst_rsp_pixels", rsp_pixels, 512'd0);
    checkOutput("rst_rsp_tag", rsp_tag, 8'd0);
    checkOutput("rst_perf_accepts", perf_accepts, 32'd0);
    checkOutput("rst_perf_stalls", perf_stalls, 32'd0);
    applyStimulus(4'b0000, 1'b1);
    rst_n = 1'b1;

    // Round-robin streaming and skipping of idle requesters.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].rv, vecs[i].rr);
      #1;
      checkOutput($sformatf("tbl%0d_req_ready", i), req_ready, vecs[i].exp_ready);
      tick();
      checkOutput($sformatf("tbl%0d_rsp_valid", i), rsp_valid, vecs[i].exp_rsp_valid);
      checkOutput($sformatf("tbl%0d_busy", i), busy, vecs[i].exp_busy);
      if (vecs[i].exp_rsp_valid) begin
        checkOutput($sformatf("tbl%0d_rsp_id", i), rsp_id, vecs[i].exp_id);
        checkOutput($sformatf("tbl%0d_rsp_tag", i), rsp_tag, tags[vecs[i].exp_id]);
        checkOutput($sformatf("tbl%0d_rsp_pixels", i), rsp_pixels, bc1_model(blocks[vecs[i].exp_id]));
      end
    end

    // Single request from requester 2: response visible two edges after accept.
    applyStimulus(4'b0100, 1'b1);
    #1;
    checkOutput("single_req_ready", req_ready, 4'b0100);
    tick();
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_rsp_early", rsp_valid, 1'b0);
    tick();
    checkOutput("single_rsp_valid", rsp_valid, 1'b1);
    checkOutput("single_rsp_id", rsp_id, 2'd2);
    checkOutput("single_rsp_tag", rsp_tag, 8'h5A);
    checkOutput("single_pixel0", rsp_pixels[31:0], 32'hFF00_00FF);
    checkOutput("single_pixels", rsp_pixels, bc1_model(64'hF800_001F_0000_0000));
    tick();
    checkOutput("single_drained", busy, 1'b0);

    // Backpressure: rsp_ready low for five clocks with requesters 0,1,2 pending.
    // Arbiter pointer sits at 3, so accepts go 0 then 1, and 2 after release.
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2;
    pend     = 4'b0111;
    accepts  = 0;
    snap_pix = '0;
    snap_id  = '0;
    snap_tag = '0;
    got.delete();
    for (int c = 0; c < 12; c++) begin
      applyStimulus(pend, (c >= 5));
      #1;
      hs = req_valid & req_ready;
      if (c < 5) accepts += $countones(hs);
      if (c >= 2 && c < 5) begin
        checkOutput($sformatf("bp_ready_low_c%0d", c), req_ready, 4'b0000);
        checkOutput($sformatf("bp_rsp_valid_c%0d", c), rsp_valid, 1'b1);
      end
      if (c == 2) begin
        snap_pix = rsp_pixels;
        snap_id  = rsp_id;
        snap_tag = rsp_tag;
      end
      if (c == 3 || c == 4) begin
        checkOutput($sformatf("bp_hold_pixels_c%0d", c), rsp_pixels, snap_pix);
        checkOutput($sformatf("bp_hold_id_c%0d", c), rsp_id, snap_id);
        checkOutput($sformatf("bp_hold_tag_c%0d", c), rsp_tag, snap_tag);
      end
      if (rsp_valid && rsp_ready) got.push_back(rsp_id);
      tick();
      pend = pend & ~hs;
    end
    checkOutput("bp_accepts", accepts, 2);
    checkOutput("bp_resp_count", got.size(), 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("bp_order%0d", i), (i < got.size()) ? int'(got[i]) : -1, exp_order[i]);
    end

    // Reset with both stages full; pointer is left at 3 before the reset.
    applyStimulus(4'b1100, 1'b0);
    tick();
    applyStimulus(4'b0100, 1'b0);
    tick();
    checkOutput("midrst_pre_busy", busy, 1'b1);
    checkOutput("midrst_pre_rsp_valid", rsp_valid, 1'b1);
    applyStimulus(4'b0000, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checkOutput("midrst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    resp_cnt = 0;
    last_id  = -1;
    for (int c = 0; c < 6; c++) begin
      applyStimulus((c == 0) ? 4'b1001 : 4'b0000, 1'b1);
      #1;
      if (c == 0) checkOutput("midrst_first_grant", req_ready, 4'b0001);
      if (rsp_valid && rsp_ready) begin
        resp_cnt++;
        last_id = int'(rsp_id);
      end
      tick();
    end
    checkOutput("midrst_resp_count", resp_cnt, 1);
    checkOutput("midrst_resp_id", last_id, 0);

    // Performance counters: 10 accepts, then 4 stalled cycles.
    rst_n = 1'b0;
    applyStimulus(4'b0000, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(4'b1111, 1'b1);
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'b1111, 1'b0);
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b0000, 1'b1);
      tick();
    end
`ifdef BC1_SCHED_PERF_EN
    checkOutput("perf_accepts", perf_accepts, 32'd10);
    checkOutput("perf_stalls", perf_stalls, 32'd4);
`else
    checkOutput("perf_accepts", perf_accepts, 32'd0);
    checkOutput("perf_stalls", perf_stalls, 32'd0);
`endif
    checkOutput("perf_final_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
